// File: rtl/sram_write_allocator_if.sv
// Request/grant handshake between write ports and the SRAM allocator.
// The master side raises requests and releases; the allocator answers.
interface sram_write_allocator_if #(
  parameter int NUM_PORTS = 16
) ();
  logic [NUM_PORTS-1:0]   req;
  logic [NUM_PORTS*6-1:0] req_len;
  logic [NUM_PORTS-1:0]   release_pkt;
  logic [NUM_PORTS-1:0]   gnt;
  logic [4:0]             gnt_sram;
  logic                   nofit;

  modport master (
    output req, req_len, release_pkt,
    input  gnt, gnt_sram, nofit
  );

  modport slave (
    input  req, req_len, release_pkt,
    output gnt, gnt_sram, nofit
  );
endinterface

// File: rtl/sram_write_allocator.sv
// Binds write ports to SRAMs: round-robin port pick, chunked search for
// the non-busy SRAM with most free space, lock held until release.
module sram_write_allocator #(
  parameter int NUM_PORTS = 16,
  parameter int NUM_SRAMS = 32,
  parameter int SCAN_W    = 8,
  parameter int SPACE_W   = 11
) (
  input  logic                         clk,
  input  logic                         rst,
  sram_write_allocator_if.slave        bus,
  input  logic [NUM_SRAMS*SPACE_W-1:0] free_space,
  output logic [NUM_PORTS*5-1:0]       port_sram,
  output logic [NUM_PORTS-1:0]         port_bound,
  output logic [NUM_SRAMS-1:0]         sram_busy
);
  localparam int NCHUNK = NUM_SRAMS / SCAN_W;
  localparam int CW  = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  localparam int PW  = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  localparam int SIW = NUM_SRAMS > 1 ? $clog2(NUM_SRAMS) : 1;

  typedef enum logic [1:0] {IDLE, SEARCH, DECIDE} state_t;

  state_t                   state, state_d;
  logic [PW-1:0]            rr_ptr, port_q;
  logic [6:0]               need;
  logic [CW-1:0]            chunk;
  logic                     best_valid;
  logic [4:0]               best_idx;
  logic [SPACE_W-1:0]       best_space;
  logic [NUM_PORTS-1:0]     gnt_q;
  logic [4:0]               gnt_sram_q;
  logic                     nofit_q;
  logic [NUM_PORTS-1:0][4:0] port_sram_q;

  logic [NUM_PORTS-1:0]     elig;
  logic                     pick_valid;
  logic [PW-1:0]            pick_port, pidx;
  logic                     cand_valid;
  logic [4:0]               cand_idx;
  logic [SPACE_W-1:0]       cand_space, sp;
  logic [SIW-1:0]           sidx;
  logic [NUM_SRAMS-1:0]     busy_d;
  logic [NUM_PORTS-1:0]     bound_d;

  assign elig         = bus.req & ~port_bound;
  assign bus.gnt      = gnt_q;
  assign bus.gnt_sram = gnt_sram_q;
  assign bus.nofit    = nofit_q;
  assign port_sram    = port_sram_q;

  always_comb begin
    state_d    = state;
    pick_valid = 1'b0;
    pick_port  = '0;
    pidx       = '0;
    cand_valid = best_valid;
    cand_idx   = best_idx;
    cand_space = best_space;
    sp         = '0;
    sidx       = '0;
    busy_d     = sram_busy;
    bound_d    = port_bound;

    for (int i = 0; i < NUM_PORTS; i++) begin
      pidx = PW'((int'(rr_ptr) + i) % NUM_PORTS);
      if (!pick_valid && elig[pidx]) begin
        pick_valid = 1'b1;
        pick_port  = pidx;
      end
    end

    // strict '>' keeps the lower index on ties, across chunks too
    for (int k = 0; k < SCAN_W; k++) begin
      sidx = SIW'(int'(chunk) * SCAN_W + k);
      sp   = free_space[int'(sidx)*SPACE_W +: SPACE_W];
      if (!sram_busy[sidx] && 12'(sp) >= 12'(need) &&
          (!cand_valid || sp > cand_space)) begin
        cand_valid = 1'b1;
        cand_idx   = 5'(sidx);
        cand_space = sp;
      end
    end

    unique case (state)
      IDLE:    if (pick_valid) state_d = SEARCH;
      SEARCH:  if (chunk == CW'(NCHUNK-1)) state_d = DECIDE;
      DECIDE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    for (int p = 0; p < NUM_PORTS; p++) begin
      if (bus.release_pkt[p] && port_bound[p]) begin
        bound_d[p]                    = 1'b0;
        busy_d[SIW'(port_sram_q[p])] = 1'b0;
      end
    end
    if (state == DECIDE && best_valid) begin
      busy_d[SIW'(best_idx)] = 1'b1;
      bound_d[port_q]        = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      port_q      <= '0;
      need        <= '0;
      chunk       <= '0;
      best_valid  <= 1'b0;
      best_idx    <= '0;
      best_space  <= '0;
      gnt_q       <= '0;
      gnt_sram_q  <= '0;
      nofit_q     <= 1'b0;
      port_sram_q <= '0;
      port_bound  <= '0;
      sram_busy   <= '0;
    end else begin
      state      <= state_d;
      sram_busy  <= busy_d;
      port_bound <= bound_d;
      gnt_q      <= '0;
      gnt_sram_q <= '0;
      nofit_q    <= 1'b0;
      unique case (state)
        IDLE: if (pick_valid) begin
          port_q     <= pick_port;
          need       <= 7'(bus.req_len[int'(pick_port)*6 +: 6]) + 7'd1;
          best_valid <= 1'b0;
          best_idx   <= '0;
          best_space <= '0;
          chunk      <= '0;
        end
        SEARCH: begin
          best_valid <= cand_valid;
          best_idx   <= cand_idx;
          best_space <= cand_space;
          chunk      <= chunk + 1'b1;
        end
        DECIDE: begin
          if (best_valid) begin
            gnt_q[port_q]       <= 1'b1;
            gnt_sram_q          <= best_idx;
            port_sram_q[port_q] <= best_idx;
          end else begin
            nofit_q <= 1'b1;
          end
          // advancing on nofit keeps an oversize packet from starving others
          rr_ptr <= (port_q == PW'(NUM_PORTS-1)) ? '0 : port_q + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_write_allocator.sv
// Bench for sram_write_allocator: directed scenarios plus randomized
// arbitration rounds against a whole-array reference model.
module tb_sram_write_allocator;
  localparam int NP = 16;
  localparam int NS = 32;
  localparam int SW = 11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_write_allocator_if #(.NUM_PORTS(NP)) bus ();
  logic [NS*SW-1:0] free_space;
  logic [NP*5-1:0]  port_sram;
  logic [NP-1:0]    port_bound;
  logic [NS-1:0]    sram_busy;

  int fs[NS];
  int len[NP];

  always_comb begin
    free_space = '0;
    for (int s = 0; s < NS; s++) free_space[s*SW +: SW] = SW'(fs[s]);
  end
  always_comb begin
    bus.req_len = '0;
    for (int p = 0; p < NP; p++) bus.req_len[p*6 +: 6] = 6'(len[p]);
  end

  sram_write_allocator #(
    .NUM_PORTS(NP), .NUM_SRAMS(NS), .SCAN_W(8), .SPACE_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .free_space(free_space), .port_sram(port_sram),
    .port_bound(port_bound), .sram_busy(sram_busy)
  );

  int tests = 0;
  int fails = 0;

  bit m_bound[NP];
  int m_sram[NP];
  bit m_busy[NS];
  int m_rr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fs(input int v);
    for (int s = 0; s < NS; s++) fs[s] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.release_pkt = '0;
    step();
    rst = 1'b0;
    for (int p = 0; p < NP; p++) begin
      m_bound[p] = 0;
      m_sram[p] = 0;
    end
    for (int s = 0; s < NS; s++) m_busy[s] = 0;
    m_rr = 0;
  endtask

  task automatic wait_result(output logic [NP-1:0] g, output logic [4:0] gs,
                             output logic nf, output int cyc);
    g = '0; gs = '0; nf = 1'b0; cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus.gnt != '0 || bus.nofit) begin
        g = bus.gnt; gs = bus.gnt_sram; nf = bus.nofit; cyc = i;
        break;
      end
    end
  endtask

  task automatic do_release(input logic [NP-1:0] r);
    bus.release_pkt = r;
    step();
    bus.release_pkt = '0;
    for (int p = 0; p < NP; p++)
      if (r[p] && m_bound[p]) begin
        m_bound[p] = 0;
        m_busy[m_sram[p]] = 0;
      end
  endtask

  // reference: first unbound requester from rr, then best SRAM over all
  function automatic void predict(input logic [NP-1:0] rq,
                                  output int port, output int sram);
    int need;
    port = -1; sram = -1;
    for (int i = 0; i < NP; i++)
      if (port < 0 && rq[(m_rr+i)%NP] && !m_bound[(m_rr+i)%NP])
        port = (m_rr + i) % NP;
    if (port >= 0) begin
      need = len[port] + 1;
      for (int s = 0; s < NS; s++)
        if (!m_busy[s] && fs[s] >= need && (sram < 0 || fs[s] > fs[sram]))
          sram = s;
    end
  endfunction

  function automatic logic [NP-1:0] pack_bound();
    logic [NP-1:0] v = '0;
    for (int p = 0; p < NP; p++) v[p] = m_bound[p];
    return v;
  endfunction

  function automatic logic [NS-1:0] pack_busy();
    logic [NS-1:0] v = '0;
    for (int s = 0; s < NS; s++) v[s] = m_busy[s];
    return v;
  endfunction

  logic [NP-1:0] g;
  logic [4:0]    gs;
  logic          nf;
  int            cyc;

  task automatic test_reset();
    set_fs(2047);
    for (int p = 0; p < NP; p++) len[p] = 0;
    do_reset();
    tests++;
    if (bus.gnt !== '0 || bus.gnt_sram !== '0 || bus.nofit !== 1'b0) begin
      fails++;
      $display("FAIL reset_hs: gnt=%h gs=%0d nofit=%b",
               bus.gnt, bus.gnt_sram, bus.nofit);
    end
    tests++;
    if (port_sram !== '0 || port_bound !== '0 || sram_busy !== '0) begin
      fails++;
      $display("FAIL reset_state: psram=%h bound=%h busy=%h exp 0",
               port_sram, port_bound, sram_busy);
    end
  endtask

  task automatic test_basic();
    do_reset();
    set_fs(2047);
    len[3] = 0;
    bus.req = NP'(1) << 3;
    wait_result(g, gs, nf, cyc);
    bus.req = '0;
    tests++;
    if (g !== 16'h0008 || gs !== 5'd0) begin
      fails++;
      $display("FAIL basic_gnt: gnt=%h gs=%0d exp 0008/0", g, gs);
    end
    tests++;
    if (cyc !== 6) begin
      fails++;
      $display("FAIL basic_latency: got %0d exp 6", cyc);
    end
    tests++;
    if (sram_busy !== 32'h1 || port_bound !== 16'h0008 ||
        port_sram[15 +: 5] !== 5'd0) begin
      fails++;
      $display("FAIL basic_lock: busy=%h bound=%h exp 1/0008",
               sram_busy, port_bound);
    end
  endtask

  task automatic test_max_space();
    do_reset();
    set_fs(100);
    fs[17] = 2000;
    fs[9] = 2000;
    len[0] = 0;
    len[1] = 0;
    bus.req = 16'h0001;
    wait_result(g, gs, nf, cyc);
    bus.req = '0;
    tests++;
    if (g !== 16'h0001 || gs !== 5'd9) begin
      fails++;
      $display("FAIL maxsp_first: gnt=%h gs=%0d exp 0001/9", g, gs);
    end
    bus.req = 16'h0002;
    wait_result(g, gs, nf, cyc);
    bus.req = '0;
    tests++;
    if (g !== 16'h0002 || gs !== 5'd17) begin
      fails++;
      $display("FAIL maxsp_second: gnt=%h gs=%0d exp 0002/17", g, gs);
    end
  endtask

  task automatic test_round_robin();
    int exp_p[3] = '{2, 5, 14};
    do_reset();
    set_fs(2047);
    len[2] = 0; len[5] = 0; len[14] = 0;
    bus.req = 16'h4024;
    for (int k = 0; k < 3; k++) begin
      wait_result(g, gs, nf, cyc);
      bus.req = bus.req & ~g;
      tests++;
      if (g !== NP'(1) << exp_p[k] || gs !== 5'(k) || cyc !== 6) begin
        fails++;
        $display("FAIL rr_order%0d: gnt=%h gs=%0d cyc=%0d exp port %0d",
                 k, g, gs, cyc, exp_p[k]);
      end
    end
    bus.req = 16'h0004;
    wait_result(g, gs, nf, cyc);
    bus.req = '0;
    tests++;
    if (g !== '0 || nf !== 1'b0) begin
      fails++;
      $display("FAIL rr_masked: gnt=%h nofit=%b exp none", g, nf);
    end
  endtask

  task automatic test_nofit();
    do_reset();
    set_fs(10);
    len[7] = 31;
    len[0] = 0;
    len[9] = 0;
    bus.req = 16'h0080;
    wait_result(g, gs, nf, cyc);
    fs[4] = 40;
    tests++;
    if (nf !== 1'b1 || g !== '0 || cyc !== 6) begin
      fails++;
      $display("FAIL nofit_pulse: nofit=%b gnt=%h cyc=%0d exp 1/0/6",
               nf, g, cyc);
    end
    wait_result(g, gs, nf, cyc);
    bus.req = '0;
    tests++;
    if (g !== 16'h0080 || gs !== 5'd4 || cyc !== 6) begin
      fails++;
      $display("FAIL nofit_retry: gnt=%h gs=%0d cyc=%0d exp 0080/4/6",
               g, gs, cyc);
    end
    bus.req = 16'h0201;
    wait_result(g, gs, nf, cyc);
    bus.req = '0;
    tests++;
    if (g !== 16'h0200) begin
      fails++;
      $display("FAIL nofit_rr8: gnt=%h exp 0200", g);
    end
  endtask

  task automatic test_release();
    logic [NP-1:0] b0;
    logic [NS-1:0] s0;
    do_reset();
    set_fs(100);
    fs[6] = 500;
    len[1] = 0;
    len[2] = 0;
    bus.req = 16'h0002;
    wait_result(g, gs, nf, cyc);
    bus.req = '0;
    tests++;
    if (gs !== 5'd6 || sram_busy[6] !== 1'b1) begin
      fails++;
      $display("FAIL rel_bind: gs=%0d busy6=%b exp 6/1", gs, sram_busy[6]);
    end
    do_release(16'h0002);
    tests++;
    if (sram_busy !== '0 || port_bound !== '0 ||
        port_sram[5 +: 5] !== 5'd6) begin
      fails++;
      $display("FAIL rel_clear: busy=%h bound=%h psram1=%0d exp 0/0/6",
               sram_busy, port_bound, port_sram[5 +: 5]);
    end
    bus.req = 16'h0002;
    wait_result(g, gs, nf, cyc);
    bus.req = '0;
    b0 = port_bound;
    s0 = sram_busy;
    do_release(16'h0004);
    tests++;
    if (port_bound !== b0 || sram_busy !== s0) begin
      fails++;
      $display("FAIL rel_unbound: bound=%h busy=%h exp %h/%h",
               port_bound, sram_busy, b0, s0);
    end
    bus.req = 16'h0004;
    wait_result(g, gs, nf, cyc);
    bus.req = '0;
    do_release(16'h0006);
    tests++;
    if (port_bound !== '0 || sram_busy !== '0) begin
      fails++;
      $display("FAIL rel_multi: bound=%h busy=%h exp 0/0",
               port_bound, sram_busy);
    end
  endtask

  task automatic test_reset_mid_search();
    do_reset();
    set_fs(2047);
    len[9] = 0;
    len[12] = 0;
    bus.req = 16'h1200;
    wait_result(g, gs, nf, cyc);
    bus.req = bus.req & ~g;
    step();
    step();
    rst = 1'b1;
    step();
    tests++;
    if (bus.gnt !== '0 || bus.nofit !== 1'b0 || port_bound !== '0 ||
        sram_busy !== '0 || port_sram !== '0) begin
      fails++;
      $display("FAIL midrst_clear: gnt=%h bound=%h busy=%h exp 0",
               bus.gnt, port_bound, sram_busy);
    end
    rst = 1'b0;
    bus.req = 16'h1200;
    wait_result(g, gs, nf, cyc);
    bus.req = bus.req & ~g;
    tests++;
    if (g !== 16'h0200 || gs !== 5'd0 || cyc !== 6) begin
      fails++;
      $display("FAIL midrst_regrant: gnt=%h gs=%0d cyc=%0d exp 0200/0/6",
               g, gs, cyc);
    end
    wait_result(g, gs, nf, cyc);
    bus.req = '0;
    tests++;
    if (g !== 16'h1000 || gs !== 5'd1) begin
      fails++;
      $display("FAIL midrst_next: gnt=%h gs=%0d exp 1000/1", g, gs);
    end
  endtask

  task automatic test_random();
    logic [NP-1:0] rq;
    int ep, es, mode;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      mode = int'($urandom_range(0, 2));
      for (int s = 0; s < NS; s++)
        case (mode)
          0: fs[s] = int'($urandom_range(0, 2047));
          1: fs[s] = ($urandom_range(0, 1) == 0) ? 500 : 1000;
          default: fs[s] = int'($urandom_range(0, 70));
        endcase
      for (int p = 0; p < NP; p++) len[p] = int'($urandom_range(0, 63));
      rq = NP'($urandom);
      predict(rq, ep, es);
      bus.req = rq;
      wait_result(g, gs, nf, cyc);
      bus.req = '0;
      tests++;
      if (ep < 0) begin
        if (g !== '0 || nf !== 1'b0) begin
          fails++;
          $display("FAIL rnd_idle%0d: gnt=%h nofit=%b exp none", it, g, nf);
        end
      end else if (es < 0) begin
        if (g !== '0 || nf !== 1'b1) begin
          fails++;
          $display("FAIL rnd_nofit%0d: gnt=%h nofit=%b exp 0/1", it, g, nf);
        end
      end else begin
        if (g !== NP'(1) << ep || gs !== 5'(es) || nf !== 1'b0) begin
          fails++;
          $display("FAIL rnd_gnt%0d: gnt=%h gs=%0d exp port %0d sram %0d",
                   it, g, gs, ep, es);
        end
      end
      if (ep >= 0) begin
        if (es >= 0) begin
          m_bound[ep] = 1;
          m_busy[es] = 1;
          m_sram[ep] = es;
        end
        m_rr = (ep + 1) % NP;
      end
      do_release(NP'($urandom & $urandom));
      tests++;
      if (port_bound !== pack_bound() || sram_busy !== pack_busy()) begin
        fails++;
        $display("FAIL rnd_state%0d: bound=%h busy=%h exp %h/%h",
                 it, port_bound, sram_busy, pack_bound(), pack_busy());
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.release_pkt = '0;
    test_reset();
    test_basic();
    test_max_space();
    test_round_robin();
    test_nofit();
    test_release();
    test_reset_mid_search();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
